// File: rtl/sqrt_iter_seq.sv
// rtl/sqrt_iter_seq.sv - iterative restoring integer square root, one root bit per clock
// Optional rounding of the root to nearest is enabled by defining SQRT_ROUND_EN.
module sqrt_iter_seq #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   radicand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder
);

  localparam int H  = WIDTH / 2;
  localparam int RW = H + 2;
  localparam int CW = $clog2(H) + 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
`ifdef SQRT_ROUND_EN
    ROUND,
`endif
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [WIDTH-1:0] r_rad;
  logic [RW-1:0]    r_rem;
  logic [H-1:0]     r_root;
  logic [CW-1:0]    r_cnt;
  logic [H-1:0]     r_root_out;
  logic [H:0]       r_rem_out;

  logic             w_accept;
  logic             w_last;
  logic [RW-1:0]    w_rem_shift;
  logic [RW-1:0]    w_trial;
  logic [RW:0]      w_sum;
  logic             w_carry;
  logic [RW-1:0]    w_rem_next;
  logic [H-1:0]     w_root_next;
`ifdef SQRT_ROUND_EN
  logic [H-1:0]     w_root_rnd;
`endif

  // busy covers every iterating state; done marks the single result-valid cycle
`ifdef SQRT_ROUND_EN
  assign busy = (r_state == CALC) || (r_state == ROUND);
`else
  assign busy = (r_state == CALC);
`endif
  assign done      = (r_state == DONE);
  assign root      = r_root_out;
  assign remainder = r_rem_out;

  assign w_accept = start && !busy;
  assign w_last   = (r_cnt == LAST);

  // The partial remainder never needs its top two bits after the shift, so the
  // truncation below only drops bits that are known to be zero.
  assign w_rem_shift = RW'({r_rem, r_rad[WIDTH-1:WIDTH-2]});
  assign w_trial     = {r_root, 2'b01};
  // Trial subtraction as addition of the two's complement; carry-out means no borrow.
  assign w_sum       = {1'b0, w_rem_shift} + {1'b0, ~w_trial} + (RW + 1)'(1);
  assign w_carry     = w_sum[RW];
  assign w_rem_next  = w_carry ? w_sum[RW-1:0] : w_rem_shift;
  assign w_root_next = {r_root[H-2:0], w_carry};

`ifdef SQRT_ROUND_EN
  // Round up when radicand is at least root^2 + root + 1, saturating at all-ones.
  assign w_root_rnd = ((r_rem > {2'b00, r_root}) && !(&r_root)) ? r_root + H'(1) : r_root;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = CALC;
      end
      CALC: begin
        if (w_last) begin
`ifdef SQRT_ROUND_EN
          w_next = ROUND;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef SQRT_ROUND_EN
      ROUND: begin
        w_next = DONE;
      end
`endif
      DONE: begin
        w_next = start ? CALC : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, one root bit per CALC cycle, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_cnt      <= '0;
      r_root_out <= '0;
      r_rem_out  <= '0;
    end else if (w_accept) begin
      r_rad  <= radicand;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (r_state == CALC) begin
      r_rad  <= {r_rad[WIDTH-3:0], 2'b00};
      r_rem  <= w_rem_next;
      r_root <= w_root_next;
      r_cnt  <= r_cnt + CW'(1);
`ifndef SQRT_ROUND_EN
      if (w_last) begin
        r_root_out <= w_root_next;
        r_rem_out  <= w_rem_next[H:0];
      end
`endif
    end
`ifdef SQRT_ROUND_EN
    else if (r_state == ROUND) begin
      r_root_out <= w_root_rnd;
      r_rem_out  <= r_rem[H:0];
    end
`endif
  end

endmodule

// File: tb/tb_sqrt_iter_seq.sv
// tb/tb_sqrt_iter_seq.sv - self-checking bench for sqrt_iter_seq (WIDTH=24)
module tb_sqrt_iter_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] radicand;
  logic        busy;
  logic        done;
  logic [11:0] root;
  logic [12:0] remainder;

  int total = 0;
  int bad   = 0;

`ifdef SQRT_ROUND_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 12;
`endif

  typedef struct {
    logic [23:0] rad;
    int          root_fl;
    int          root_rd;
    int          rem;
  } vec_t;

  vec_t vecs[10];

  sqrt_iter_seq #(.WIDTH(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .radicand  (radicand),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_trunc(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic int model_root(input int n);
    int r = model_trunc(n);
`ifdef SQRT_ROUND_EN
    if ((n - r * r > r) && (r < 4095)) r++;
`endif
    return r;
  endfunction

  function automatic int exp_root(input vec_t v);
`ifdef SQRT_ROUND_EN
    return v.root_rd;
`else
    return v.root_fl;
`endif
  endfunction

  task automatic run_op(input logic [23:0] rad, output int r, output int m, output int lat);
    @(negedge clk);
    start    = 1'b1;
    radicand = rad;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
    chk("busy_fall", busy, 0);
    r = root;
    m = remainder;
  endtask

  initial begin
    int r, m, lat;
    int n;
    bit seen;

    vecs[0] = '{24'd144,      12,   12,   0};
    vecs[1] = '{24'd0,        0,    0,    0};
    vecs[2] = '{24'd16777215, 4095, 4095, 8190};
    vecs[3] = '{24'd99,       9,    10,   18};
    vecs[4] = '{24'd3,        1,    2,    2};
    vecs[5] = '{24'd8,        2,    3,    4};
    vecs[6] = '{24'd6,        2,    2,    2};
    vecs[7] = '{24'd1,        1,    1,    0};
    vecs[8] = '{24'd4194304,  2048, 2048, 0};
    vecs[9] = '{24'd16769025, 4095, 4095, 0};

    rst_n    = 1'b0;
    start    = 1'b0;
    radicand = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_root", root, 0);
    chk("reset_rem", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].rad, r, m, lat);
      chk($sformatf("vec%0d_root", i), r, exp_root(vecs[i]));
      chk($sformatf("vec%0d_rem", i), m, vecs[i].rem);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
    end

    // Randomized against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      if (i % 4 == 0) n = int'($urandom_range(0, 1000));
      else n = int'($urandom & 32'h00FF_FFFF);
      run_op(24'(n), r, m, lat);
      chk($sformatf("rnd%0d_root(n=%0d)", i, n), r, model_root(n));
      chk($sformatf("rnd%0d_rem(n=%0d)", i, n), m, n - model_trunc(n) * model_trunc(n));
    end

    // Start pulsed while busy must be ignored
    @(negedge clk);
    start    = 1'b1;
    radicand = 24'd1000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        start    = 1'b1;
        radicand = 24'd4;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    chk("ign_done_seen", done, 1);
    chk("ign_root", root, 1000);
    chk("ign_rem", remainder, 0);
    chk("ign_lat", lat, LAT);

    // Back-to-back with start held through DONE
    @(negedge clk);
    start    = 1'b1;
    radicand = 24'd49;
    @(posedge clk);
    #1;
    radicand = 24'd50;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk("b2b_first_done", done, 1);
    chk("b2b_first_root", root, 7);
    chk("b2b_first_rem", remainder, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_rebusy", busy, 1);
    chk("b2b_done_single", done, 0);
    chk("b2b_hold_root", root, 7);
    chk("b2b_hold_rem", remainder, 0);
    lat = 1;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk("b2b_second_done", done, 1);
    chk("b2b_spacing", lat, LAT + 1);
    chk("b2b_second_root", root, 7);
    chk("b2b_second_rem", remainder, 1);

    // Asynchronous reset in the middle of a calculation
    @(negedge clk);
    start    = 1'b1;
    radicand = 24'd1000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_root", root, 0);
    chk("arst_rem", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("arst_no_done", 32'(seen), 0);
    run_op(24'd81, r, m, lat);
    chk("arst_fresh_root", r, 9);
    chk("arst_fresh_rem", m, 0);
    chk("arst_fresh_lat", lat, LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
